// File: rtl/accel_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accel_reg_pkg
//  Description : Shared definitions for the accelerator register front end:
//                register byte offsets, CTRL/STATUS bit positions, the
//                command FSM state type and an offset helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package accel_reg_pkg;

    // Register byte offsets relative to the window base (addr[7:0]).
    // Offset 0x54 belongs to the lock's queue word and is deliberately absent.
    localparam logic [7:0] c_off_key0   = 8'h00;
    localparam logic [7:0] c_off_din0   = 8'h10;
    localparam logic [7:0] c_off_ctrl   = 8'h20;
    localparam logic [7:0] c_off_status = 8'h24;
    localparam logic [7:0] c_off_dout0  = 8'h30;

    // CTRL write bits
    localparam int c_ctrl_start = 0;
    localparam int c_ctrl_mode  = 1;

    // STATUS read bits
    localparam int c_stat_busy  = 0;
    localparam int c_stat_done  = 1;
    localparam int c_stat_error = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    // Byte offset of 32-bit word idx within a bank starting at base.
    function automatic logic [7:0] word_off(input logic [7:0] base, input int idx);
        return base + 8'(idx * 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/accel_reg_frontend_if.sv
`default_nettype none
// ============================================================================
//  Module      : accel_reg_frontend_if
//  Description : Arbitrated register bus between the lock arbiter (master)
//                and the accelerator front end (slave).
//                addr_i  - byte address        wr_en_i  - write strobe
//                select_i- chip select          wdata_i  - write data
//                rdata_o - read data (combinational from slave state)
//  Revision    : 1.0 - initial release
// ============================================================================
interface accel_reg_frontend_if;
    logic [31:0] addr_i;
    logic        wr_en_i;
    logic        select_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;

    modport master (
        output addr_i,
        output wr_en_i,
        output select_i,
        output wdata_i,
        input  rdata_o
    );

    modport slave (
        input  addr_i,
        input  wr_en_i,
        input  select_i,
        input  wdata_i,
        output rdata_o
    );
endinterface
`default_nettype wire

// File: rtl/accel_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : accel_watchdog
//  Description : 32-bit saturating cycle counter guarding one core command.
//                clk, rst  - clock / synchronous active-high reset
//                i_clear   - zero the counter
//                i_enable  - count this cycle
//                o_expired - counter reaches TIMEOUT_CYCLES-1 at this edge
//  Revision    : 1.0 - initial release
// ============================================================================
module accel_watchdog #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [31:0] c_limit =
        (TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1;

    logic [31:0] r_count;
    logic [31:0] w_count_inc;

    // Saturate rather than wrap so a stuck command can never look fresh again.
    assign w_count_inc = (r_count == 32'hFFFF_FFFF) ? r_count : r_count + 32'd1;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_count_inc;
        end
    end

    // Looks at the post-increment value so the FSM leaves WAIT on the same
    // edge the counter reaches the limit: with the ISSUE cycle included this
    // gives exactly TIMEOUT_CYCLES cycles from start pulse to ERROR.
    assign o_expired = i_enable && (w_count_inc >= c_limit);

endmodule
`default_nettype wire

// File: rtl/accel_reg_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : accel_reg_frontend
//  Description : Register-mapped front end for the 128-bit cipher core,
//                sitting behind the multi-core lock arbiter. Holds key and
//                input block, launches the core, captures the result, and
//                wipes all session state on lock release.
//                clk, rst       - clock / synchronous active-high reset
//                session_end_i  - lock-release pulse, soft clear
//                bus            - arbitrated register bus (slave side)
//                core_start_o   - one-cycle start pulse to the core
//                core_mode_o    - 0 encrypt / 1 decrypt
//                core_key_o     - {KEY3..KEY0}
//                core_blk_o     - {DIN3..DIN0}
//                core_done_i    - one-cycle done pulse from the core
//                core_result_i  - result, valid with core_done_i
//  Revision    : 1.0 - initial release
// ============================================================================
module accel_reg_frontend
    import accel_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1024,
    parameter int          KEY_WORDS      = 4,
    parameter int          BLK_WORDS      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     session_end_i,
    accel_reg_frontend_if.slave      bus,
    output logic                     core_start_o,
    output logic                     core_mode_o,
    output logic [32*KEY_WORDS-1:0]  core_key_o,
    output logic [32*BLK_WORDS-1:0]  core_blk_o,
    input  logic                     core_done_i,
    input  logic [32*BLK_WORDS-1:0]  core_result_i
);

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_key  [KEY_WORDS];
    logic [31:0] r_din  [BLK_WORDS];
    logic [31:0] r_dout [BLK_WORDS];
    logic        r_mode;

    logic        w_clear;
    logic [31:0] w_off_full;
    logic [7:0]  w_off;
    logic        w_unused_off_hi;
    logic        w_wr;
    logic        w_busy;
    logic        w_ctrl_wr;
    logic        w_start_cmd;
    logic        w_dout_capture;
    logic        w_wd_expired;
    logic [31:0] w_status;
    logic [31:0] w_rdata;

    // Lock release wipes exactly what reset wipes.
    assign w_clear = rst || session_end_i;

    // Only the low byte of the base-relative address is decoded.
    assign w_off_full      = bus.addr_i - BASE_ADDR;
    assign w_off           = w_off_full[7:0];
    assign w_unused_off_hi = ^w_off_full[31:8];

    assign w_wr        = bus.select_i && bus.wr_en_i;
    assign w_busy      = (r_state == ISSUE) || (r_state == WAIT);
    // Register writes are blocked while busy so the core inputs stay stable.
    assign w_ctrl_wr   = w_wr && !w_busy && (w_off == c_off_ctrl);
    assign w_start_cmd = w_ctrl_wr && bus.wdata_i[c_ctrl_start];

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        core_start_o   = 1'b0;
        w_dout_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_cmd) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                core_start_o = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: begin
                // A done in the timeout cycle still counts as success.
                if (core_done_i) begin
                    w_dout_capture = 1'b1;
                    w_state_next   = DONE;
                end else if (w_wd_expired) begin
                    w_state_next = ERROR;
                end
            end
            DONE, ERROR: begin
                if (w_ctrl_wr) begin
                    w_state_next = bus.wdata_i[c_ctrl_start] ? ISSUE : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    accel_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (session_end_i || (r_state == ISSUE)),
        .i_enable  (r_state == WAIT),
        .o_expired (w_wd_expired)
    );

    // ------------------------------------------------------------------
    // Session registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_mode <= 1'b0;
        end else if (w_start_cmd) begin
            r_mode <= bus.wdata_i[c_ctrl_mode];
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                r_key[i] <= '0;
            end
            for (int i = 0; i < BLK_WORDS; i++) begin
                r_din[i] <= '0;
            end
        end else if (w_wr && !w_busy) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                if (w_off == word_off(c_off_key0, i)) begin
                    r_key[i] <= bus.wdata_i;
                end
            end
            for (int i = 0; i < BLK_WORDS; i++) begin
                if (w_off == word_off(c_off_din0, i)) begin
                    r_din[i] <= bus.wdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            for (int i = 0; i < BLK_WORDS; i++) begin
                r_dout[i] <= '0;
            end
        end else if (w_dout_capture) begin
            for (int i = 0; i < BLK_WORDS; i++) begin
                r_dout[i] <= core_result_i[32*i +: 32];
            end
        end
    end

    // ------------------------------------------------------------------
    // Core-facing outputs
    // ------------------------------------------------------------------
    assign core_mode_o = r_mode;

    for (genvar gi = 0; gi < KEY_WORDS; gi++) begin : g_key_pack
        assign core_key_o[32*gi +: 32] = r_key[gi];
    end

    for (genvar gi = 0; gi < BLK_WORDS; gi++) begin : g_blk_pack
        assign core_blk_o[32*gi +: 32] = r_din[gi];
    end

    // ------------------------------------------------------------------
    // Read mux: zero-latency, zero when not selected or unmapped
    // ------------------------------------------------------------------
    always_comb begin
        w_status               = '0;
        w_status[c_stat_busy]  = w_busy;
        w_status[c_stat_done]  = (r_state == DONE);
        w_status[c_stat_error] = (r_state == ERROR);
    end

    always_comb begin
        w_rdata = '0;
        if (bus.select_i) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                if (w_off == word_off(c_off_key0, i)) begin
                    w_rdata = r_key[i];
                end
            end
            for (int i = 0; i < BLK_WORDS; i++) begin
                if (w_off == word_off(c_off_din0, i)) begin
                    w_rdata = r_din[i];
                end
                if (w_off == word_off(c_off_dout0, i)) begin
                    w_rdata = r_dout[i];
                end
            end
            if (w_off == c_off_ctrl) begin
                w_rdata = {30'b0, r_mode, 1'b0};
            end
            if (w_off == c_off_status) begin
                w_rdata = w_status;
            end
        end
    end

    assign bus.rdata_o = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_accel_reg_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accel_reg_frontend
//  Description : Scoreboard bench for accel_reg_frontend. Stimulus pushes
//                expected observations into queues; a negedge monitor pops
//                and compares whenever a read/observation is presented or
//                the core start pulse fires.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_accel_reg_frontend;

    localparam int c_k_rdata  = 0;
    localparam int c_k_key_lo = 1;
    localparam int c_k_blk_hi = 2;
    localparam int c_k_start  = 3;

    localparam logic [127:0] c_result = 128'h0011_2233_4455_6677_0123_4567_89AB_CDEF;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         session_end_i;
    logic         core_start_o;
    logic         core_mode_o;
    logic [127:0] core_key_o;
    logic [127:0] core_blk_o;
    logic         core_done_i;
    logic [127:0] core_result_i;

    chk_t         q_chk[$];
    logic         q_start[$];
    logic         chk_req   = 1'b0;
    logic         final_req = 1'b0;
    int           checks    = 0;
    int           errors    = 0;

    accel_reg_frontend_if bus ();

    accel_reg_frontend #(
        .BASE_ADDR      (32'h0000_0000),
        .TIMEOUT_CYCLES (32'd16),
        .KEY_WORDS      (4),
        .BLK_WORDS      (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .session_end_i (session_end_i),
        .bus           (bus),
        .core_start_o  (core_start_o),
        .core_mode_o   (core_mode_o),
        .core_key_o    (core_key_o),
        .core_blk_o    (core_blk_o),
        .core_done_i   (core_done_i),
        .core_result_i (core_result_i)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        chk_t        c;
        logic        exp_mode;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            if (core_start_o) begin
                checks++;
                if (q_start.size() == 0) begin
                    errors++;
                    $display("FAIL start_pulse: unexpected core_start_o=1 (mode=%0b), required none", core_mode_o);
                end else begin
                    exp_mode = q_start.pop_front();
                    if (core_mode_o !== exp_mode) begin
                        errors++;
                        $display("FAIL start_mode: core_mode_o=%0b required %0b", core_mode_o, exp_mode);
                    end
                end
            end
            if (chk_req) begin
                checks++;
                if (q_chk.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: observation requested with no expected entry");
                end else begin
                    c = q_chk.pop_front();
                    case (c.kind)
                        c_k_key_lo: act = core_key_o[31:0];
                        c_k_blk_hi: act = core_blk_o[127:96];
                        c_k_start:  act = {31'b0, core_start_o};
                        default:    act = bus.rdata_o;
                    endcase
                    if (act !== c.exp) begin
                        errors++;
                        $display("FAIL %s: got 0x%08h required 0x%08h", c.name, act, c.exp);
                    end
                end
            end
            if (final_req) begin
                checks++;
                if (q_chk.size() != 0 || q_start.size() != 0) begin
                    errors++;
                    $display("FAIL leftover_expect: %0d observations and %0d start pulses never seen, required 0",
                             q_chk.size(), q_start.size());
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL tb_timeout: simulation did not reach the summary in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all start and end 1 ns after a rising edge)
    // ------------------------------------------------------------------
    task automatic expect_obs(input string name, input int kind, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.exp  = exp;
        q_chk.push_back(c);
        chk_req = 1'b1;
    endtask

    task automatic rd(input logic [31:0] a, input logic sel, input logic [31:0] exp, input string name);
        bus.addr_i   = a;
        bus.wr_en_i  = 1'b0;
        bus.select_i = sel;
        expect_obs(name, c_k_rdata, exp);
        @(posedge clk);
        #1;
        chk_req      = 1'b0;
        bus.select_i = 1'b0;
    endtask

    task automatic obs(input int kind, input logic [31:0] exp, input string name);
        expect_obs(name, kind, exp);
        @(posedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic sel, input logic [31:0] d);
        bus.addr_i   = a;
        bus.wdata_i  = d;
        bus.wr_en_i  = 1'b1;
        bus.select_i = sel;
        @(posedge clk);
        #1;
        bus.wr_en_i  = 1'b0;
        bus.select_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic core_done_pulse(input logic [127:0] res);
        core_result_i = res;
        core_done_i   = 1'b1;
        @(posedge clk);
        #1;
        core_done_i   = 1'b0;
    endtask

    task automatic session_end_pulse();
        session_end_i = 1'b1;
        @(posedge clk);
        #1;
        session_end_i = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst           = 1'b1;
        session_end_i = 1'b0;
        core_done_i   = 1'b0;
        core_result_i = '0;
        bus.addr_i    = '0;
        bus.wr_en_i   = 1'b0;
        bus.select_i  = 1'b0;
        bus.wdata_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        rd(32'h24, 1'b1, 32'h0, "status_reset");
        for (int i = 0; i < 4; i++) begin
            rd(32'h30 + 32'(4 * i), 1'b1, 32'h0, "dout_reset");
        end
        rd(32'h20, 1'b1, 32'h0, "ctrl_reset");
        obs(c_k_start, 32'h0, "start_reset");

        // Register write / readback and core-facing packing
        wr(32'h00, 1'b1, 32'h0011_2233);
        wr(32'h1C, 1'b1, 32'hDEAD_BEEF);
        rd(32'h00, 1'b1, 32'h0011_2233, "key0_readback");
        rd(32'h1C, 1'b1, 32'hDEAD_BEEF, "din3_readback");
        obs(c_k_key_lo, 32'h0011_2233, "core_key_lo");
        obs(c_k_blk_hi, 32'hDEAD_BEEF, "core_blk_hi");

        // Decrypt command; core answers 10 cycles after the start pulse
        q_start.push_back(1'b1);
        wr(32'h20, 1'b1, 32'h3);                 // cycle 0: ISSUE
        rd(32'h24, 1'b1, 32'h1, "status_issue");
        rd(32'h24, 1'b1, 32'h1, "status_wait");
        idle(8);                                  // now in cycle 10
        core_done_pulse(c_result);
        rd(32'h24, 1'b1, 32'h2, "status_done");
        rd(32'h30, 1'b1, 32'h89AB_CDEF, "dout0_result");
        rd(32'h3C, 1'b1, 32'h0011_2233, "dout3_result");
        rd(32'h20, 1'b1, 32'h2, "ctrl_mode_readback");

        // Timeout: relaunch from DONE in encrypt mode, core never answers
        q_start.push_back(1'b0);
        wr(32'h20, 1'b1, 32'h1);                 // cycle 0: ISSUE
        idle(15);                                 // now in cycle 15
        rd(32'h24, 1'b1, 32'h1, "status_pre_timeout");
        rd(32'h24, 1'b1, 32'h4, "status_timeout");
        core_done_pulse({128{1'b1}});
        rd(32'h30, 1'b1, 32'h89AB_CDEF, "dout0_after_stray_done");
        rd(32'h24, 1'b1, 32'h4, "status_error_held");
        wr(32'h20, 1'b1, 32'h0);
        rd(32'h24, 1'b1, 32'h0, "status_error_cleared");

        // Writes ignored while busy; session end aborts mid-WAIT
        q_start.push_back(1'b1);
        wr(32'h20, 1'b1, 32'h3);                 // cycle 0: ISSUE
        wr(32'h00, 1'b1, 32'hFFFF_FFFF);
        rd(32'h00, 1'b1, 32'h0011_2233, "key0_write_while_busy");
        rd(32'h24, 1'b1, 32'h1, "status_busy");
        session_end_pulse();
        rd(32'h24, 1'b1, 32'h0, "status_session_end");
        rd(32'h00, 1'b1, 32'h0, "key0_session_end");
        rd(32'h1C, 1'b1, 32'h0, "din3_session_end");
        rd(32'h30, 1'b1, 32'h0, "dout0_session_end");
        rd(32'h20, 1'b1, 32'h0, "mode_session_end");
        core_done_pulse(c_result);
        rd(32'h30, 1'b1, 32'h0, "dout0_late_done");
        rd(32'h24, 1'b1, 32'h0, "status_late_done");

        // Unmapped offsets and unselected accesses
        wr(32'h04, 1'b1, 32'hCAFE_0001);
        wr(32'h54, 1'b1, 32'h1111_1111);
        wr(32'h40, 1'b1, 32'h2222_2222);
        wr(32'h04, 1'b0, 32'h3333_3333);
        wr(32'h20, 1'b0, 32'h0000_0001);
        rd(32'h04, 1'b1, 32'hCAFE_0001, "key1_after_ignored_writes");
        rd(32'h54, 1'b1, 32'h0, "read_lock_queue_word");
        rd(32'h40, 1'b1, 32'h0, "read_unmapped_0x40");
        rd(32'h04, 1'b0, 32'h0, "read_without_select");
        rd(32'h24, 1'b1, 32'h0, "status_no_launch_unselected");

        // Session end beats a same-cycle register write
        session_end_i = 1'b1;
        wr(32'h08, 1'b1, 32'hABCD_0123);
        session_end_i = 1'b0;
        rd(32'h08, 1'b1, 32'h0, "key2_session_end_priority");
        rd(32'h04, 1'b1, 32'h0, "key1_session_end");

        final_req = 1'b1;
        idle(4);
    end

endmodule
`default_nettype wire

// File: doc/accel_reg_frontend.md
Name: accel_reg_frontend

Overview:
- Register-mapped front end directly downstream of the multi-core lock arbiter. It consumes the arbitrated address, write-enable, select and write data, and returns read data to the lock.
- Holds the key and input block, launches the 128-bit cipher core through a start/done handshake, and captures the result. A per-command watchdog guards the core.
- Clears all session state on the lock-release pulse so the next core never sees the previous core's key or data.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base of the register window. Only addr bits [7:0] are decoded relative to base; the word at offset 0x54 is the lock's queue word and is never decoded here.
- TIMEOUT_CYCLES, 32'd1024, cycles allowed from start until core_done before ERROR.
- KEY_WORDS, 4, 32-bit key words.
- BLK_WORDS, 4, 32-bit block words.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- session_end_i  in  1  one-cycle pulse from the lock on release; acts as a soft clear.
- addr_i  in  32  arbitrated byte address.
- wr_en_i  in  1  write strobe.
- select_i  in  1  accelerator chip-select.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data to the lock.
- core_start_o  out  1  one-cycle start pulse to the cipher core.
- core_mode_o  out  1  0 = encrypt, 1 = decrypt.
- core_key_o  out  128  {KEY3..KEY0}.
- core_blk_o  out  128  {DIN3..DIN0}.
- core_done_i  in  1  one-cycle done pulse from the core.
- core_result_i  in  128  valid in the cycle core_done_i is high.

Behaviour:
- Register map (byte offsets from BASE_ADDR):
  - KEY0-3 at 0x00-0x0C: RW.
  - DIN0-3 at 0x10-0x1C: RW.
  - CTRL at 0x20: W. bit0 = start, bit1 = mode. Reads as {30'b0, mode, 1'b0}.
  - STATUS at 0x24: R. bit0 = busy, bit1 = done, bit2 = error.
  - DOUT0-3 at 0x30-0x3C: R.
  - Unmapped offsets, and any access with select_i = 0: reads return 0, writes are ignored.
- Write: takes effect on the clk edge when select_i & wr_en_i are high and the address decodes.
- Read: rdata_o is combinational from registered state, zero latency, and is 0 whenever select_i = 0.
- FSM states: IDLE, ISSUE, WAIT, DONE, ERROR.
  - IDLE: a CTRL write with bit0 = 1 latches mode and goes to ISSUE.
  - ISSUE: core_start_o = 1 for exactly this one cycle. Clear watchdog, go to WAIT.
  - WAIT: on core_done_i, capture core_result_i into DOUT and go to DONE. If the watchdog reaches TIMEOUT_CYCLES-1 without done, go to ERROR.
  - DONE / ERROR: a CTRL start write re-launches via ISSUE. A CTRL write with bit0 = 0 returns to IDLE and clears the done/error flags.
- STATUS flags:
  - busy = ISSUE or WAIT.
  - done = DONE.
  - error = ERROR.
- Writes to KEY, DIN or CTRL while busy are ignored, so core inputs stay stable. Reads are always allowed.
- core_done_i is ignored outside WAIT. core_done_i and the timeout in the same cycle resolve to done (DONE wins).
- Watchdog is a 32-bit counter. It does not count outside WAIT and saturates, never wrapping.
- rst or session_end_i:
  - KEY, DIN, DOUT and mode go to 0; FSM goes to IDLE; watchdog goes to 0.
  - core_start_o = 0 and rdata_o = 0 with no select.
  - This applies mid-operation too; a subsequent core_done_i from the aborted command is ignored.
- rst and session_end_i behave identically. session_end_i takes priority over a same-cycle register write.

Decomposition:
- Package accel_reg_pkg holds:
  - the register offset localparams;
  - the STATUS bit indices;
  - the fsm state_t enum (IDLE, ISSUE, WAIT, DONE, ERROR).
- One sub-module, accel_watchdog: counter with clear/enable and a saturating expired flag.

Test Plan:
- Reset then read STATUS at 0x24 -> rdata_o = 0; all DOUT reads = 0; core_start_o = 0.
- Write KEY0 = 32'h0011_2233 and DIN3 = 32'hDEAD_BEEF, then read back -> same values; core_key_o[31:0] = 32'h0011_2233, core_blk_o[127:96] = 32'hDEAD_BEEF.
- Write CTRL = 32'h3; core model asserts done 10 cycles after start with result 128'h0123...CDEF:
  - core_start_o pulses once, with core_mode_o = 1;
  - STATUS = 1 until done, then STATUS = 2;
  - DOUT0 = 32'h89AB_CDEF.
- TIMEOUT_CYCLES = 16 with no core_done_i -> STATUS = 4 exactly 16 cycles after the start pulse. A later stray core_done_i leaves DOUT unchanged.
- While busy, write KEY0 = 32'hFFFF_FFFF -> KEY0 unchanged. Pulse session_end_i mid-WAIT -> STATUS = 0, KEY0 = 0, and a late core_done_i is ignored.
- Write to offset 0x54 and to 0x40 with select_i = 1, plus any write with select_i = 0 -> no register changes; reads of those offsets return 0.
